// File: rtl/mem_arbiter.sv
// Arbitrates I- and D-cache block transfers onto one memory port; D has priority, bounded by D_MAX_CONSEC.
// Latency: grant edge, MEM_LATENCY access cycles, one DONE cycle, one IDLE cycle; requesters hold req until done.
module mem_arbiter #(
    parameter int MEM_LATENCY  = 4,
    parameter int D_MAX_CONSEC = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_done,
    output logic [63:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_done,
    output logic [63:0] d_rdata,
    output logic [15:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [63:0] m_wdata,
    input  logic [63:0] m_rdata,
    output logic        busy,
    output logic [15:0] i_acc_cnt,
    output logic [15:0] d_acc_cnt
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic       OWN_I    = 1'b0;
    localparam logic       OWN_D    = 1'b1;

    localparam logic [3:0] LAST_CYC = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] DMAX     = 4'(D_MAX_CONSEC);

    logic [1:0]  r_state;
    logic        r_owner;
    logic        r_we;
    logic [15:0] r_addr;
    logic [63:0] r_wdata;
    logic [3:0]  r_cyc;
    logic [3:0]  r_dcons;
    logic [63:0] r_i_rdata;
    logic [63:0] r_d_rdata;
    logic [15:0] r_i_acc_cnt;
    logic [15:0] r_d_acc_cnt;

    logic        w_any_req;
    logic        w_grant_d;
    logic        w_access;
    logic        w_done;

    // A waiting I request overrides D once D has taken DMAX grants in a row.
    assign w_any_req = i_req | d_req;
    assign w_grant_d = d_req & ~(i_req & (r_dcons == DMAX));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_owner     <= OWN_I;
            r_we        <= 1'b0;
            r_addr      <= 16'h0000;
            r_wdata     <= 64'h0;
            r_cyc       <= 4'd0;
            r_dcons     <= 4'd0;
            r_i_rdata   <= 64'h0;
            r_d_rdata   <= 64'h0;
            r_i_acc_cnt <= 16'h0000;
            r_d_acc_cnt <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!i_req) begin
                        r_dcons <= 4'd0;
                    end
                    if (w_any_req) begin
                        r_state <= S_ACCESS;
                        r_cyc   <= 4'd0;
                        if (w_grant_d) begin
                            r_owner <= OWN_D;
                            r_we    <= d_we;
                            r_addr  <= {d_addr[15:2], 2'b00};
                            r_wdata <= d_wdata;
                            if (i_req) begin
                                r_dcons <= r_dcons + 4'd1;
                            end
                        end else begin
                            r_owner <= OWN_I;
                            r_we    <= 1'b0;
                            r_addr  <= {i_addr[15:2], 2'b00};
                            r_wdata <= 64'h0;
                            r_dcons <= 4'd0;
                        end
                    end
                end
                S_ACCESS: begin
                    r_cyc <= r_cyc + 4'd1;
                    if (r_cyc == LAST_CYC) begin
                        r_state <= S_DONE;
                        if (!r_we) begin
                            if (r_owner == OWN_D) begin
                                r_d_rdata <= m_rdata;
                            end else begin
                                r_i_rdata <= m_rdata;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    if (r_owner == OWN_D) begin
                        r_d_acc_cnt <= r_d_acc_cnt + 16'd1;
                    end else begin
                        r_i_acc_cnt <= r_i_acc_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory-side outputs decode from registered state, so reset zeroes them immediately.
    assign w_access  = (r_state == S_ACCESS);
    assign w_done    = (r_state == S_DONE);

    assign m_read    = w_access & ~r_we;
    assign m_write   = w_access & r_we;
    assign m_address = w_access ? r_addr : 16'h0000;
    assign m_wdata   = (w_access && r_we) ? r_wdata : 64'h0;

    assign i_done    = w_done & (r_owner == OWN_I);
    assign d_done    = w_done & (r_owner == OWN_D);
    assign busy      = (r_state != S_IDLE);

    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign i_acc_cnt = r_i_acc_cnt;
    assign d_acc_cnt = r_d_acc_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter at MEM_LATENCY=4, D_MAX_CONSEC=2.
module tb_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_done;
    logic [63:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_done;
    logic [63:0] d_rdata;
    logic [15:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [63:0] m_wdata;
    logic [63:0] m_rdata;
    logic        busy;
    logic [15:0] i_acc_cnt;
    logic [15:0] d_acc_cnt;

    int tests;
    int errors;

    localparam logic [63:0] X_ARB = 64'hC0FF_EE00_1234_5678;
    localparam logic [63:0] X_RST = 64'hA5A5_0F0F_F0F0_5A5A;
    localparam logic [63:0] X_WRP = 64'h1111_2222_3333_4444;

    mem_arbiter #(.MEM_LATENCY(4), .D_MAX_CONSEC(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .busy(busy),
        .i_acc_cnt(i_acc_cnt), .d_acc_cnt(d_acc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        i_req = 1'b0; i_addr = 16'h0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 16'h0; d_wdata = 64'h0; m_rdata = 64'h0;
        tick(); tick();
        tests++;
        if ({busy, m_read, m_write, i_done, d_done} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, m_read, m_write, i_done, d_done});
        end
        tests++;
        if ({i_rdata, d_rdata, m_wdata, m_address, i_acc_cnt, d_acc_cnt} !== '0) begin
            errors++; $display("FAIL reset_data: got nonzero data/counter outputs, expected all 0");
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_i_read();
        i_req = 1'b1; i_addr = 16'h0047;
        tick();
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) i_addr = 16'hFFFF;
            if (c == 4) m_rdata = 64'h0123_4567_89AB_CDEF;
            tests++;
            if ({m_read, m_write, busy} !== 3'b101 || m_address !== 16'h0044 || m_wdata !== 64'h0) begin
                errors++;
                $display("FAIL i_read_cyc%0d: rd/wr/busy=%b addr=%h wdata=%h expected 101 0044 0", c, {m_read, m_write, busy}, m_address, m_wdata);
            end
            tick();
        end
        tests++;
        if (i_done !== 1'b1 || d_done !== 1'b0 || m_read !== 1'b0 || i_rdata !== 64'h0123_4567_89AB_CDEF) begin
            errors++;
            $display("FAIL i_read_done: i_done=%b d_done=%b m_read=%b i_rdata=%h expected 1 0 0 0123456789abcdef", i_done, d_done, m_read, i_rdata);
        end
        tick();
        i_req = 1'b0; m_rdata = 64'h0;
        tests++;
        if (i_done !== 1'b0 || busy !== 1'b0 || i_acc_cnt !== 16'd1) begin
            errors++; $display("FAIL i_read_after: i_done=%b busy=%b i_acc_cnt=%0d expected 0 0 1", i_done, busy, i_acc_cnt);
        end
    endtask

    task automatic test_d_write();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h1238; d_wdata = 64'hDEAD_BEEF_0000_1111;
        m_rdata = 64'h5555_AAAA_5555_AAAA;
        tick();
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) d_wdata = 64'h0;
            tests++;
            if ({m_write, m_read} !== 2'b10 || m_address !== 16'h1238 || m_wdata !== 64'hDEAD_BEEF_0000_1111) begin
                errors++;
                $display("FAIL d_write_cyc%0d: wr/rd=%b addr=%h wdata=%h expected 10 1238 deadbeef00001111", c, {m_write, m_read}, m_address, m_wdata);
            end
            tick();
        end
        tests++;
        if (d_done !== 1'b1 || i_done !== 1'b0 || d_rdata !== 64'h0) begin
            errors++; $display("FAIL d_write_done: d_done=%b i_done=%b d_rdata=%h expected 1 0 0", d_done, i_done, d_rdata);
        end
        tick();
        d_req = 1'b0; d_we = 1'b0; m_rdata = 64'h0;
        tests++;
        if (d_acc_cnt !== 16'd1 || d_rdata !== 64'h0 || d_done !== 1'b0) begin
            errors++; $display("FAIL d_write_after: d_acc_cnt=%0d d_rdata=%h d_done=%b expected 1 0 0", d_acc_cnt, d_rdata, d_done);
        end
    endtask

    task automatic test_arbitration();
        logic own [0:3];
        int   at  [0:3];
        int   n;
        n = 0;
        i_req = 1'b1; i_addr = 16'h0100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h2003; m_rdata = X_ARB;
        for (int cyc = 1; cyc <= 40 && n < 3; cyc++) begin
            tick();
            if (cyc == 13) begin
                tests++;
                if (dut.r_dcons !== 4'd0 || m_address !== 16'h0100) begin
                    errors++; $display("FAIL arb_i_grant: dcons=%0d m_address=%h expected 0 0100", dut.r_dcons, m_address);
                end
            end
            if (d_done && n < 4) begin own[n] = 1'b1; at[n] = cyc; n++; end
            if (i_done && n < 4) begin own[n] = 1'b0; at[n] = cyc; n++; end
        end
        tick();
        i_req = 1'b0; d_req = 1'b0; m_rdata = 64'h0;
        tests++;
        if (n !== 3) begin
            errors++; $display("FAIL arb_count: got %0d done pulses expected 3", n);
        end else begin
            tests++;
            if (own[0] !== 1'b1 || own[1] !== 1'b1 || own[2] !== 1'b0) begin
                errors++; $display("FAIL arb_order: got D?=%b%b%b expected 110", own[0], own[1], own[2]);
            end
            tests++;
            if (at[0] !== 5 || at[1] !== 11 || at[2] !== 17) begin
                errors++; $display("FAIL arb_timing: got cycles %0d %0d %0d expected 5 11 17", at[0], at[1], at[2]);
            end
        end
        tests++;
        if (d_acc_cnt !== 16'd3 || i_acc_cnt !== 16'd2 || i_rdata !== X_ARB || d_rdata !== X_ARB) begin
            errors++;
            $display("FAIL arb_after: d_cnt=%0d i_cnt=%0d i_rdata=%h d_rdata=%h expected 3 2 %h %h", d_acc_cnt, i_acc_cnt, i_rdata, d_rdata, X_ARB, X_ARB);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        int   got;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h3000; d_wdata = 64'hFEED_FACE_CAFE_0001;
        tick(); tick();
        tests++;
        if (m_write !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre: m_write=%b busy=%b expected 1 1", m_write, busy);
        end
        reset_n = 1'b0;
        #1;
        tests++;
        if ({m_write, m_read, busy, d_done} !== 4'b0 || m_address !== 16'h0 || m_wdata !== 64'h0 ||
            d_acc_cnt !== 16'h0 || i_acc_cnt !== 16'h0 || i_rdata !== 64'h0 || d_rdata !== 64'h0) begin
            errors++;
            $display("FAIL rst_mid_now: wr/rd/busy/done=%b addr=%h wdata=%h cnts=%0d/%0d expected all 0", {m_write, m_read, busy, d_done}, m_address, m_wdata, i_acc_cnt, d_acc_cnt);
        end
        d_req = 1'b0; d_we = 1'b0;
        tick();
        reset_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (d_done || i_done || busy) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL rst_mid_nodone: got activity after abort expected none");
        end
        i_req = 1'b1; i_addr = 16'h00A5; m_rdata = X_RST;
        got = -1;
        for (int cyc = 1; cyc <= 20 && got < 0; cyc++) begin
            tick();
            if (i_done) got = cyc;
        end
        tests++;
        if (got !== 5 || i_rdata !== X_RST) begin
            errors++; $display("FAIL rst_mid_retry: done cycle %0d i_rdata=%h expected 5 %h", got, i_rdata, X_RST);
        end
        tick();
        i_req = 1'b0; m_rdata = 64'h0;
        tests++;
        if (i_acc_cnt !== 16'd1 || d_acc_cnt !== 16'd0) begin
            errors++; $display("FAIL rst_mid_cnt: i_cnt=%0d d_cnt=%0d expected 1 0", i_acc_cnt, d_acc_cnt);
        end
    endtask

    task automatic test_wrap();
        int got;
        force dut.r_d_acc_cnt = 16'hFFFF;
        #1;
        release dut.r_d_acc_cnt;
        tests++;
        if (d_acc_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_preload: d_acc_cnt=%h expected ffff", d_acc_cnt);
        end
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h4441; m_rdata = X_WRP;
        got = -1;
        for (int cyc = 1; cyc <= 20 && got < 0; cyc++) begin
            tick();
            if (d_done) got = cyc;
        end
        tick();
        d_req = 1'b0; m_rdata = 64'h0;
        tests++;
        if (got !== 5 || d_acc_cnt !== 16'h0000 || i_acc_cnt !== 16'd1 || d_rdata !== X_WRP) begin
            errors++;
            $display("FAIL wrap_cnt: done cycle %0d d_cnt=%h i_cnt=%0d d_rdata=%h expected 5 0000 1 %h", got, d_acc_cnt, i_acc_cnt, d_rdata, X_WRP);
        end
    endtask

    initial begin
        tests = 0;
        errors = 0;
        test_reset();
        test_i_read();
        test_d_write();
        test_arbitration();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LATENCY, default 4: memory access cycles per transfer; legal values 1..15.
REQ-002 Parameter D_MAX_CONSEC, default 2: consecutive D grants allowed while I is waiting; legal values 1..15.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 i_req  in  1  I-cache refill request; held high until i_done.
REQ-006 i_addr  in  16  I-cache miss address.
REQ-007 i_done  out  1  one-cycle pulse: I transfer complete, i_rdata valid.
REQ-008 i_rdata  out  64  refill block (4 words) for I-cache.
REQ-009 d_req  in  1  D-cache request; held high until d_done.
REQ-010 d_we  in  1  1 = write-back of d_wdata, 0 = refill read.
REQ-011 d_addr  in  16  D-cache access address.
REQ-012 d_wdata  in  64  write-back block.
REQ-013 d_done  out  1  one-cycle pulse: D transfer complete; d_rdata valid if the transfer was a read.
REQ-014 d_rdata  out  64  refill block for D-cache.
REQ-015 m_address  out  16  unified memory address, block-aligned.
REQ-016 m_read / m_write  out  1 each  memory strobes; never high together.
REQ-017 m_wdata  out  64  write data to memory.
REQ-018 m_rdata  in  64  read data from memory; valid in the last access cycle.
REQ-019 busy  out  1  high in any state other than IDLE.
REQ-020 i_acc_cnt / d_acc_cnt  out  16 each  completed transfers per requester; wrap at 16'hFFFF to 0.

Function
REQ-021 The FSM SHALL have states IDLE, ACCESS and DONE, plus registers owner (I/D), we, addr, wdata, cyc (4 bit) and dcons (4 bit).
REQ-022 IDLE with neither request: stay IDLE; all strobes and done pulses 0.
REQ-023 IDLE with a request: go to ACCESS at the next edge; latch owner, we (0 for I), addr = {req_addr[15:2], 2'b00}, wdata; cyc <= 0.
REQ-024 Arbitration: D wins over I, except when i_req=1 and dcons == D_MAX_CONSEC, in which case I wins.
REQ-025 dcons: increments on each D grant while i_req=1; clears on each I grant and whenever i_req=0 in IDLE.
REQ-026 ACCESS: m_address = addr; m_read = !we; m_write = we; m_wdata = wdata when we=1, else 0; cyc increments each cycle.
REQ-027 ACCESS with cyc == MEM_LATENCY-1: go to DONE at the edge; if we=0, capture m_rdata into the owner's rdata register.
REQ-028 DONE: pulse the owner's done for exactly one cycle, increment the owner's acc_cnt, return to IDLE; strobes 0.
REQ-029 Latency: a request sampled in IDLE at edge 0 gets strobes in cycles 1..MEM_LATENCY and done in cycle MEM_LATENCY+1; IDLE is one cycle before the next grant.
REQ-030 The requester SHALL drop req on the edge where done is sampled high; req still high in the following IDLE is treated as a new request.
REQ-031 Inputs that change or requests that drop during ACCESS/DONE SHALL be ignored; the latched transfer completes and done still pulses.
REQ-032 i_rdata / d_rdata SHALL hold their last captured value until the next read by the same owner; a D write-back leaves d_rdata unchanged.
REQ-033 Simultaneous i_req and d_req in IDLE with dcons < D_MAX_CONSEC: D is granted, and I waits with i_req held.

Reset
REQ-034 reset_n low, at any time including mid-ACCESS, SHALL immediately set state = IDLE and clear cyc, dcons, owner, we, addr and wdata.
REQ-035 The same reset SHALL clear i_rdata, d_rdata, m_address, m_wdata, both counters, all strobes and both done outputs to 0; an aborted transfer produces no done.

Verification
REQ-036 I-only: i_req=1, i_addr=16'h0047, m_rdata=64'h0123_4567_89AB_CDEF in cycle 4 -> m_read=1 with m_address=16'h0044 in cycles 1-4; i_done=1 and i_rdata=64'h0123456789ABCDEF in cycle 5; i_acc_cnt=1.
REQ-037 D write-back: d_req=1, d_we=1, d_addr=16'h1238, d_wdata=64'hDEAD_BEEF_0000_1111 -> m_write=1, m_address=16'h1238, m_wdata equal to d_wdata in cycles 1-4; d_done in cycle 5; d_rdata unchanged.
REQ-038 Simultaneous i_req and d_req held -> grant order D, D, I (D_MAX_CONSEC=2); i_done arrives after two d_done pulses; dcons=0 after the I grant.
REQ-039 Reset mid-transfer: assert reset_n=0 in cycle 2 of ACCESS -> outputs 0 immediately, busy=0, no done; a request issued after reset completes normally.
REQ-040 Counter wrap: preload d_acc_cnt to 16'hFFFF via 65535 D transfers (or force), complete one more -> d_acc_cnt=0.
